// File: rtl/alu_seq_ctrl.sv
// Accumulator sequencer for the 16-bit combinational ALU.
// Accepts commands, iterates ALU passes, returns result and flags.
module alu_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cb,
  output logic             rsp_cb_any,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             use_cb;

  logic       accept;
  logic       is_load;
  logic       is_clr;
  logic       is_alu;
  logic       is_arith;
  logic [1:0] ctrl_map;

  assign accept   = cmd_valid && cmd_ready;
  assign rsp_data = acc;

  always_comb begin
    is_load  = 1'b0;
    is_clr   = 1'b0;
    is_alu   = 1'b0;
    is_arith = 1'b0;
    ctrl_map = 2'b00;
    unique case (cmd_op)
      3'b000: is_load = 1'b1;
      3'b001: begin
        is_alu   = 1'b1;
        is_arith = 1'b1;
        ctrl_map = 2'b00;
      end
      3'b010: begin
        is_alu   = 1'b1;
        ctrl_map = 2'b01;
      end
      3'b011: begin
        is_alu   = 1'b1;
        ctrl_map = 2'b10;
      end
      3'b100: begin
        is_alu   = 1'b1;
        is_arith = 1'b1;
        ctrl_map = 2'b11;
      end
      3'b101: is_clr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      use_cb      <= 1'b0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_cb      <= 1'b0;
      rsp_cb_any  <= 1'b0;
      rsp_err     <= 1'b0;
      alu_control <= 2'b00;
      alu_a       <= '0;
      alu_b       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready  <= 1'b0;
            rsp_cb     <= 1'b0;
            rsp_cb_any <= 1'b0;
            rsp_err    <= 1'b0;
            if (is_alu) begin
              state       <= EXEC;
              cnt         <= cmd_count;
              use_cb      <= is_arith;
              alu_control <= ctrl_map;
              alu_a       <= acc;
              alu_b       <= cmd_operand;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              if (is_load) acc <= cmd_operand;
              else if (is_clr) acc <= '0;
              else rsp_err <= 1'b1;
            end
          end
        end
        EXEC: begin
          // alu_a tracks acc so the next pass sees the updated value
          acc   <= alu_result;
          alu_a <= alu_result;
          cnt   <= cnt - 1'b1;
          if (use_cb) begin
            rsp_cb     <= alu_cb;
            rsp_cb_any <= rsp_cb_any | alu_cb;
          end
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: ALU model plus accumulator reference model,
// directed cases followed by random commands.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_operand;
  logic [3:0]  cmd_count;
  logic [1:0]  alu_control;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic        alu_cb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_cb;
  logic        rsp_cb_any;
  logic        rsp_err;

  logic        junk;
  int          n_chk;
  int          n_pass;
  logic [15:0] macc;

  alu_seq_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_operand(cmd_operand),
    .cmd_count  (cmd_count),
    .alu_control(alu_control),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_cb     (alu_cb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_cb     (rsp_cb),
    .rsp_cb_any (rsp_cb_any),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // CB is meaningless for OR/XOR, so feed it noise there
  always @(negedge clk) junk <= 1'($urandom);

  always_comb begin
    logic [16:0] s;
    s = '0;
    alu_result = '0;
    alu_cb = 1'b0;
    case (alu_control)
      2'b00: begin
        s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = s[15:0];
        alu_cb = s[16];
      end
      2'b01: begin
        alu_result = alu_a | alu_b;
        alu_cb = junk;
      end
      2'b10: begin
        alu_result = alu_a ^ alu_b;
        alu_cb = junk;
      end
      default: begin
        alu_result = alu_a - alu_b;
        alu_cb = (alu_a < alu_b);
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic model(input logic [2:0] op, input logic [15:0] b,
                       input logic [3:0] cnt, output logic [15:0] d,
                       output logic cb, output logic any,
                       output logic err);
    int a;
    cb = 0;
    any = 0;
    err = 0;
    case (op)
      3'd0: macc = b;
      3'd5: macc = 0;
      3'd1, 3'd2, 3'd3, 3'd4: begin
        for (int i = 0; i <= int'(cnt); i++) begin
          a = int'(macc);
          cb = 0;
          if (op == 3'd1) begin
            cb = (a + int'(b)) > 65535;
            macc = 16'(a + int'(b));
          end else if (op == 3'd4) begin
            cb = a < int'(b);
            macc = 16'(a - int'(b));
          end else if (op == 3'd2) macc = macc | b;
          else macc = macc ^ b;
          any = any | cb;
        end
      end
      default: err = 1;
    endcase
    d = macc;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [15:0] b,
                         input logic [3:0] cnt, input int hold);
    logic [15:0] ed;
    logic        ecb, eany, eerr;
    logic [15:0] d0;
    bit          alu_op;
    int          w, lat;
    alu_op = (op >= 3'd1 && op <= 3'd4);
    model(op, b, cnt, ed, ecb, eany, eerr);
    @(negedge clk);
    cmd_valid = 1;
    cmd_op = op;
    cmd_operand = b;
    cmd_count = cnt;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid && alu_op)
        chk("exec_ctrl", 32'(alu_control), 32'(op - 3'd1));
    end while (!rsp_valid && lat < 40);
    chk("latency", lat, alu_op ? int'(cnt) + 2 : 1);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_cb", rsp_cb, ecb);
    chk("rsp_cb_any", rsp_cb_any, eany);
    chk("rsp_err", rsp_err, eerr);
    d0 = rsp_data;
    repeat (hold) begin
      cmd_valid = 1;
      cmd_op = 3'd0;
      cmd_operand = 16'($urandom);
      chk("bp_ready", cmd_ready, 0);
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, d0);
    end
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    cmd_valid = 0;
    @(negedge clk);
    chk("rsp_drop", rsp_valid, 0);
    chk("ready_back", cmd_ready, 1);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    macc = 0;
    rst_n = 0;
    cmd_valid = 0;
    cmd_op = 0;
    cmd_operand = 0;
    cmd_count = 0;
    rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_ctrl", alu_control, 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    run_cmd(3'd0, 16'h1234, 4'd0, 0);
    run_cmd(3'd0, 16'hFFFF, 4'd0, 0);
    run_cmd(3'd1, 16'h0001, 4'd0, 0);
    run_cmd(3'd0, 16'h0000, 4'd0, 0);
    run_cmd(3'd1, 16'h0003, 4'd4, 0);
    run_cmd(3'd0, 16'h0002, 4'd0, 0);
    run_cmd(3'd4, 16'h0001, 4'd3, 0);
    run_cmd(3'd0, 16'hABCD, 4'd0, 0);
    run_cmd(3'd3, 16'h0FF0, 4'd0, 5);
    run_cmd(3'd7, 16'h5555, 4'd2, 0);
    run_cmd(3'd1, 16'h0000, 4'd0, 0);
    run_cmd(3'd5, 16'h1111, 4'd0, 0);

    // reset in the middle of a long ADD
    @(negedge clk);
    cmd_valid = 1;
    cmd_op = 3'd1;
    cmd_operand = 16'h0101;
    cmd_count = 4'd15;
    @(posedge clk);
    #1 cmd_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_ctrl", alu_control, 0);
    @(negedge clk);
    rst_n = 1;
    macc = 0;
    run_cmd(3'd1, 16'h0005, 4'd0, 0);

    for (int i = 0; i < 40; i++) begin
      run_cmd(3'($urandom_range(0, 7)), 16'($urandom),
              4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing initiator for the 16-bit combinational ALU (ports Control[1:0], A, B, nBitOut, CB). It accepts accumulator commands over a valid/ready interface and drives the ALU operand and control lines. It captures the ALU result and carry/borrow flag, iterating a command up to 16 times, and returns the result on a valid/ready response channel. It sits between the datapath command issuer and the ALU instance.

Parameters:
WIDTH, 16, operand/accumulator width; must match ALU width.
CNT_W, 4, width of the iteration count field.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  3  000 LOAD, 001 ADD, 010 OR, 011 XOR, 100 SUB, 101 CLR, 110/111 illegal
cmd_operand  input  WIDTH  B operand, or load value
cmd_count  input  CNT_W  iterations minus one (0 = 1 pass, 15 = 16 passes)
alu_control  output  2  to ALU Control: 00 ADD, 01 OR, 10 XOR, 11 SUB
alu_a  output  WIDTH  to ALU A (accumulator)
alu_b  output  WIDTH  to ALU B (latched operand)
alu_result  input  WIDTH  from ALU nBitOut
alu_cb  input  1  from ALU CB (carry for ADD, borrow for SUB)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  WIDTH  accumulator after the command
rsp_cb  output  1  CB of the final iteration
rsp_cb_any  output  1  OR of CB across all iterations
rsp_err  output  1  illegal opcode

Behaviour:
- Reset: the synchronous rst_n=0 sampled at a clk edge forces the following values. State IDLE. Accumulator, operand latch and iteration counter are 0. cmd_ready=0 during reset and 1 in the first cycle after release. rsp_valid=0, rsp_data=0, rsp_cb=0, rsp_cb_any=0, rsp_err=0, alu_control=00, alu_a=0, alu_b=0.
- Reset mid-operation: the command is abandoned, no response is produced, and the accumulator is cleared.
- cmd_ready=1 only in IDLE. A command is accepted when cmd_valid && cmd_ready at a clk edge. cmd_ready is independent of cmd_valid.
- States:
  - IDLE: on accept, latch op, operand and count; clear cb_any.
    - LOAD, CLR and illegal opcodes go to RESP.
    - ADD, OR, XOR and SUB go to EXEC.
  - EXEC: alu_a=acc, alu_b=operand latch, alu_control=mapped op. These are all registered, so they are stable for the whole cycle. The ALU is combinational, so alu_result/alu_cb are sampled at the end of this same cycle.
    - On that edge: acc<=alu_result, last_cb<=alu_cb, cb_any|=alu_cb, counter decrements.
    - If the counter was 0, go to RESP; otherwise stay in EXEC for the next pass, using the updated acc.
  - RESP: rsp_valid=1, and rsp_* hold stable until rsp_valid && rsp_ready, then go to IDLE. rsp_data=acc.
- Per-command results:
  - LOAD: acc<=operand.
  - CLR: acc<=0.
  - Both return rsp_cb=0 and rsp_cb_any=0.
  - Illegal opcode: acc unchanged, rsp_err=1, rsp_cb=0.
  - rsp_err=0 for all legal commands.
- CB flag for OR/XOR: ALU CB is don't-care, so the block forces rsp_cb=0 and does not update cb_any.
- Latency:
  - LOAD/CLR/illegal: accept at edge N, rsp_valid=1 from cycle N+1.
  - ALU op with count k: rsp_valid=1 from cycle N+1+(k+1).
- Arithmetic: modulo 2^WIDTH wrap, taken directly from the ALU. No saturation.
- Backpressure: while in RESP, cmd_ready=0. A new command can be accepted in the cycle after the response handshake, giving one response per two cycles maximum for LOAD.
- Outside EXEC, alu_* outputs hold their last driven values.

Test Plan:
- Reset then LOAD 0x1234 -> cmd_ready 1 cycle after reset release; rsp_valid next cycle; rsp_data=0x1234, rsp_cb=0, rsp_err=0.
- LOAD 0xFFFF, ADD 0x0001 count 0 -> rsp_data=0x0000, rsp_cb=1, rsp_cb_any=1; alu_control=00 during the single EXEC cycle.
- LOAD 0x0000, ADD 0x0003 count 4 -> five EXEC cycles; rsp_data=0x000F, rsp_cb=0, rsp_cb_any=0; rsp_valid asserts 6 cycles after accept.
- LOAD 0x0002, SUB 0x0001 count 3 -> rsp_data=0xFFFE, rsp_cb_any=1 (borrow on pass 3), rsp_cb=0 on final pass, per ALU CB polarity.
- rsp_ready held low 5 cycles after XOR response -> rsp_valid/rsp_data stable, cmd_ready=0, second cmd_valid not accepted until handshake; cmd_op=111 -> rsp_err=1, acc unchanged on following LOAD-free readback via ADD 0 count 0.
- Assert rst_n=0 mid-EXEC of ADD count 15 -> next cycle outputs at reset values, no rsp_valid; following ADD 0x0005 count 0 returns 0x0005.
